axi_write_arbiter: RTL and testbench

Shares one downstream AXI write channel (AW/W/B) between two upstream write requesters, for example the L2 cache and a DMA/blit engine.
Runs one burst at a time with an explicit response phase, so the next grant never overlaps an outstanding B response.
Regenerates WLAST from its own beat counter and flags requester WLAST mismatches.
Sits between the write requesters and the AXI interconnect's write-capable slave port.

---
 rtl/axi_write_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// Shares one downstream AXI write port (AW/W/B) between two requesters, one burst at a time.
// WLAST is regenerated from the latched burst length; requester WLAST disagreements pulse protocol_error.
module axi_write_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int DATA_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_awvalid_i,
  output logic              r0_awready_o,
  input  logic [31:0]       r0_awaddr_i,
  input  logic [7:0]        r0_awlen_i,
  input  logic              r0_wvalid_i,
  output logic              r0_wready_o,
  input  logic [DATA_W-1:0] r0_wdata_i,
  input  logic              r0_wlast_i,
  output logic              r0_bvalid_o,
  input  logic              r0_bready_i,
  output logic [1:0]        r0_bresp_o,
  output logic              r0_arready_o,
  output logic              r0_rvalid_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  input  logic              r1_awvalid_i,
  output logic              r1_awready_o,
  input  logic [31:0]       r1_awaddr_i,
  input  logic [7:0]        r1_awlen_i,
  input  logic              r1_wvalid_i,
  output logic              r1_wready_o,
  input  logic [DATA_W-1:0] r1_wdata_i,
  input  logic              r1_wlast_i,
  output logic              r1_bvalid_o,
  input  logic              r1_bready_i,
  output logic [1:0]        r1_bresp_o,
  output logic              r1_arready_o,
  output logic              r1_rvalid_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              d_awvalid_o,
  input  logic              d_awready_i,
  output logic [31:0]       d_awaddr_o,
  output logic [7:0]        d_awlen_o,
  output logic              d_wvalid_o,
  input  logic              d_wready_i,
  output logic [DATA_W-1:0] d_wdata_o,
  output logic              d_wlast_o,
  input  logic              d_bvalid_i,
  output logic              d_bready_o,
  input  logic [1:0]        d_bresp_i,
  output logic              d_arvalid_o,
  output logic              d_rready_o,
  output logic              protocol_error
);

  typedef enum logic [1:0] {
    ARBITRATE     = 2'd0,
    ISSUE_ADDRESS = 2'd1,
    ACTIVE_BURST  = 2'd2,
    WAIT_RESPONSE = 2'd3
  } state_e;

  localparam logic FIXED_PRIO = (PRIORITY_MODE == 32'sd1);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] burst_address_q, burst_address_d;
  logic [7:0]  beats_left_q, beats_left_d;

  logic              pick_s;
  logic              g_wvalid_s;
  logic              g_wlast_s;
  logic              g_bready_s;
  logic [DATA_W-1:0] g_wdata_s;
  logic              last_beat_s;
  logic              beat_s;
  logic              b_done_s;

  // Contention: fixed mode always favours r0, round-robin favours whoever was not served last.
  assign pick_s      = (r0_awvalid_i && r1_awvalid_i) ? (FIXED_PRIO ? 1'b0 : ~last_grant_q)
                                                      : r1_awvalid_i;
  assign g_wvalid_s  = grant_q ? r1_wvalid_i : r0_wvalid_i;
  assign g_wlast_s   = grant_q ? r1_wlast_i  : r0_wlast_i;
  assign g_wdata_s   = grant_q ? r1_wdata_i  : r0_wdata_i;
  assign g_bready_s  = grant_q ? r1_bready_i : r0_bready_i;
  assign last_beat_s = (beats_left_q == 8'd0);
  assign beat_s      = (state_q == ACTIVE_BURST) && g_wvalid_s && d_wready_i;
  assign b_done_s    = (state_q == WAIT_RESPONSE) && d_bvalid_i && g_bready_s;

  assign r0_arready_o = 1'b0;
  assign r0_rvalid_o  = 1'b0;
  assign r0_rdata_o   = {DATA_W{1'b0}};
  assign r1_arready_o = 1'b0;
  assign r1_rvalid_o  = 1'b0;
  assign r1_rdata_o   = {DATA_W{1'b0}};
  assign d_arvalid_o  = 1'b0;
  assign d_rready_o   = 1'b0;

  // State and burst context registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ARBITRATE;
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      burst_address_q <= 32'd0;
      beats_left_q    <= 8'd0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      burst_address_q <= burst_address_d;
      beats_left_q    <= beats_left_d;
    end
  end

  // Next-state and context update.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    burst_address_d = burst_address_q;
    beats_left_d    = beats_left_q;
    case (state_q)
      ARBITRATE: begin
        if (r0_awvalid_i || r1_awvalid_i) begin
          grant_d         = pick_s;
          burst_address_d = pick_s ? r1_awaddr_i : r0_awaddr_i;
          beats_left_d    = pick_s ? r1_awlen_i  : r0_awlen_i;
          state_d         = ISSUE_ADDRESS;
        end else begin
          state_d = ARBITRATE;
        end
      end
      ISSUE_ADDRESS: begin
        if (d_awready_i) begin
          state_d = ACTIVE_BURST;
        end else begin
          state_d = ISSUE_ADDRESS;
        end
      end
      ACTIVE_BURST: begin
        if (beat_s && last_beat_s) begin
          state_d = WAIT_RESPONSE;
        end else if (beat_s) begin
          beats_left_d = beats_left_q - 8'd1;
        end else begin
          state_d = ACTIVE_BURST;
        end
      end
      WAIT_RESPONSE: begin
        if (b_done_s) begin
          last_grant_d = grant_q;
          state_d      = ARBITRATE;
        end else begin
          state_d = WAIT_RESPONSE;
        end
      end
      default: begin
        state_d = ARBITRATE;
      end
    endcase
  end

  // Channel steering: only the granted requester ever sees a ready/valid from downstream.
  always_comb begin
    r0_awready_o   = 1'b0;
    r1_awready_o   = 1'b0;
    r0_wready_o    = 1'b0;
    r1_wready_o    = 1'b0;
    r0_bvalid_o    = 1'b0;
    r1_bvalid_o    = 1'b0;
    r0_bresp_o     = 2'b00;
    r1_bresp_o     = 2'b00;
    d_awvalid_o    = 1'b0;
    d_awaddr_o     = burst_address_q;
    d_awlen_o      = beats_left_q;
    d_wvalid_o     = 1'b0;
    d_wdata_o      = {DATA_W{1'b0}};
    d_wlast_o      = 1'b0;
    d_bready_o     = 1'b0;
    protocol_error = 1'b0;
    case (state_q)
      ARBITRATE: begin
        d_awvalid_o = 1'b0;
      end
      ISSUE_ADDRESS: begin
        d_awvalid_o  = 1'b1;
        r0_awready_o = ~grant_q & d_awready_i;
        r1_awready_o = grant_q & d_awready_i;
      end
      ACTIVE_BURST: begin
        d_wvalid_o     = g_wvalid_s;
        d_wdata_o      = g_wdata_s;
        d_wlast_o      = last_beat_s;
        r0_wready_o    = ~grant_q & d_wready_i;
        r1_wready_o    = grant_q & d_wready_i;
        protocol_error = beat_s && (g_wlast_s != last_beat_s);
      end
      WAIT_RESPONSE: begin
        d_bready_o  = g_bready_s;
        r0_bvalid_o = ~grant_q & d_bvalid_i;
        r1_bvalid_o = grant_q & d_bvalid_i;
        r0_bresp_o  = grant_q ? 2'b00 : d_bresp_i;
        r1_bresp_o  = grant_q ? d_bresp_i : 2'b00;
      end
      default: begin
        d_awvalid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench: instance 0 runs round-robin, instance 1 fixed priority.
// Expected bursts are queued in expected grant order and popped on each downstream AW handshake.
module tb_axi_write_arbiter;
  localparam int DW = 32;

  typedef struct {
    int          r;
    logic [31:0] addr;
    logic [7:0]  len;
    int          bad;
  } burst_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          awvalid [2][2];
  logic [31:0]   awaddr  [2][2];
  logic [7:0]    awlen   [2][2];
  logic          wvalid  [2][2];
  logic [DW-1:0] wdata   [2][2];
  logic          wlast   [2][2];
  logic          bready  [2][2];
  logic          awready [2][2];
  logic          wready  [2][2];
  logic          bvalid  [2][2];
  logic [1:0]    bresp   [2][2];
  logic          arready [2][2];
  logic          rvalid  [2][2];
  logic [DW-1:0] rdata   [2][2];
  logic          d_awvalid [2];
  logic [31:0]   d_awaddr  [2];
  logic [7:0]    d_awlen   [2];
  logic          d_wvalid  [2];
  logic [DW-1:0] d_wdata   [2];
  logic          d_wlast   [2];
  logic          d_bready  [2];
  logic          d_arvalid [2];
  logic          d_rready  [2];
  logic          perr      [2];
  logic          d_awready [2];
  logic          d_wready  [2];
  logic          d_bvalid  [2];
  logic [1:0]    d_bresp   [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    axi_write_arbiter #(.PRIORITY_MODE(m), .DATA_W(DW)) u_dut (
      .clk(clk), .reset(rst_n),
      .r0_awvalid_i(awvalid[m][0]), .r0_awready_o(awready[m][0]), .r0_awaddr_i(awaddr[m][0]),
      .r0_awlen_i(awlen[m][0]), .r0_wvalid_i(wvalid[m][0]), .r0_wready_o(wready[m][0]),
      .r0_wdata_i(wdata[m][0]), .r0_wlast_i(wlast[m][0]), .r0_bvalid_o(bvalid[m][0]),
      .r0_bready_i(bready[m][0]), .r0_bresp_o(bresp[m][0]), .r0_arready_o(arready[m][0]),
      .r0_rvalid_o(rvalid[m][0]), .r0_rdata_o(rdata[m][0]),
      .r1_awvalid_i(awvalid[m][1]), .r1_awready_o(awready[m][1]), .r1_awaddr_i(awaddr[m][1]),
      .r1_awlen_i(awlen[m][1]), .r1_wvalid_i(wvalid[m][1]), .r1_wready_o(wready[m][1]),
      .r1_wdata_i(wdata[m][1]), .r1_wlast_i(wlast[m][1]), .r1_bvalid_o(bvalid[m][1]),
      .r1_bready_i(bready[m][1]), .r1_bresp_o(bresp[m][1]), .r1_arready_o(arready[m][1]),
      .r1_rvalid_o(rvalid[m][1]), .r1_rdata_o(rdata[m][1]),
      .d_awvalid_o(d_awvalid[m]), .d_awready_i(d_awready[m]), .d_awaddr_o(d_awaddr[m]),
      .d_awlen_o(d_awlen[m]), .d_wvalid_o(d_wvalid[m]), .d_wready_i(d_wready[m]),
      .d_wdata_o(d_wdata[m]), .d_wlast_o(d_wlast[m]), .d_bvalid_i(d_bvalid[m]),
      .d_bready_o(d_bready[m]), .d_bresp_i(d_bresp[m]), .d_arvalid_o(d_arvalid[m]),
      .d_rready_o(d_rready[m]), .protocol_error(perr[m])
    );
  end

  int     total = 0;
  int     bad   = 0;
  burst_t pend[$];
  burst_t sb[$];
  int     aw_stall = 0;
  int     b_delay  = 0;
  bit     wr_toggle = 1'b0;
  int     first_aw_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic burst_t mk(input int r, input logic [31:0] addr, input logic [7:0] len, input int badb);
    burst_t b;
    b.r = r; b.addr = addr; b.len = len; b.bad = badb;
    return b;
  endfunction

  task automatic req_exp(input int r, input logic [31:0] addr, input logic [7:0] len, input int badb);
    pend.push_back(mk(r, addr, len, badb));
    sb.push_back(mk(r, addr, len, badb));
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 2; r++) begin
        awvalid[m][r] = 1'b0; awaddr[m][r] = 32'd0; awlen[m][r] = 8'd0; wvalid[m][r] = 1'b0;
        wdata[m][r] = '0; wlast[m][r] = 1'b0; bready[m][r] = 1'b0;
      end
      d_awready[m] = 1'b0; d_wready[m] = 1'b0; d_bvalid[m] = 1'b0; d_bresp[m] = 2'b00;
    end
  endtask

  task automatic check_quiet(input string tag, input int m);
    check_eq(tag, {d_awvalid[m], d_wvalid[m], d_wlast[m], d_bready[m], awready[m][0], awready[m][1],
                   wready[m][0], wready[m][1], bvalid[m][0], bvalid[m][1], perr[m]}, 11'd0);
  endtask

  // Cycle-level requester + downstream slave model; checks every cycle against the scoreboard.
  task automatic run(input int m, input int abort_beats, input int max_cyc);
    int     cur_i[2];
    bit     aw_done[2];
    int     nbeats, stall_cnt, b_cnt, cyc, g, o;
    bit     have_cur, in_resp, tog, done;
    logic   exp_pe;
    burst_t ex, b;
    aw_done[0] = 1'b0; aw_done[1] = 1'b0;
    nbeats = 0; stall_cnt = 0; b_cnt = 0; cyc = 0; g = 0; o = 1;
    have_cur = 1'b0; in_resp = 1'b0; tog = 1'b0; done = 1'b0;
    first_aw_cyc = -1;
    ex = mk(0, 32'd0, 8'd0, -1);
    @(posedge clk); #1;
    while (!done) begin
      for (int r = 0; r < 2; r++) begin
        cur_i[r] = -1;
        for (int k = 0; k < pend.size(); k++) if (pend[k].r == r && cur_i[r] < 0) cur_i[r] = k;
        if (cur_i[r] >= 0) begin
          b = pend[cur_i[r]];
          awvalid[m][r] = !aw_done[r]; awaddr[m][r] = b.addr; awlen[m][r] = b.len;
          wvalid[m][r] = aw_done[r];
          wdata[m][r] = {b.addr[23:0], nbeats[7:0]};
          wlast[m][r] = aw_done[r] && (nbeats == int'(b.len) || nbeats == b.bad);
          bready[m][r] = 1'b1;
        end else begin
          awvalid[m][r] = 1'b0; wvalid[m][r] = 1'b0; wlast[m][r] = 1'b0; bready[m][r] = 1'b0;
        end
      end
      d_awready[m] = (stall_cnt >= aw_stall);
      d_wready[m]  = wr_toggle ? tog : 1'b1;
      d_bvalid[m]  = in_resp && (b_cnt >= b_delay);
      d_bresp[m]   = have_cur ? ex.addr[5:4] : 2'b00;
      @(negedge clk);
      if (!have_cur && d_awvalid[m] && first_aw_cyc < 0) first_aw_cyc = cyc;
      if (have_cur) begin
        g = ex.r; o = 1 - ex.r;
        check_eq("ungranted_awready", awready[m][o], 1'b0);
        check_eq("ungranted_wready", wready[m][o], 1'b0);
        check_eq("ungranted_bvalid", bvalid[m][o], 1'b0);
      end
      if (in_resp) begin
        check_eq("no_grant_in_resp", {d_awvalid[m], awready[m][0], awready[m][1], d_wvalid[m]}, 4'd0);
        if (d_bvalid[m]) begin
          check_eq("b_mirror", {bvalid[m][g], bresp[m][g], d_bready[m]}, {1'b1, ex.addr[5:4], 1'b1});
          check_eq("beat_count", nbeats, int'(ex.len) + 1);
          pend.delete(cur_i[g]);
          aw_done[g] = 1'b0; have_cur = 1'b0; in_resp = 1'b0; b_cnt = 0;
          if (pend.size() == 0) done = 1'b1;
        end else begin
          check_eq("b_early", bvalid[m][g], 1'b0);
          b_cnt++;
        end
      end else begin
        check_eq("b_idle", {d_bready[m], bvalid[m][0], bvalid[m][1]}, 3'd0);
        if (d_awvalid[m] && d_awready[m]) begin
          check_eq("sb_size", sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            ex = sb.pop_front(); have_cur = 1'b1; g = ex.r;
            check_eq("aw_addr", d_awaddr[m], ex.addr);
            check_eq("aw_len", d_awlen[m], ex.len);
            check_eq("grant", {awready[m][1], awready[m][0]}, (ex.r == 1) ? 2'b10 : 2'b01);
            aw_done[ex.r] = 1'b1; stall_cnt = 0; nbeats = 0;
          end
        end else if (d_awvalid[m]) begin
          stall_cnt++;
        end
        if (d_wvalid[m] && d_wready[m]) begin
          if (have_cur) begin
            exp_pe = (nbeats == ex.bad) && (nbeats != int'(ex.len));
            check_eq("w_data", d_wdata[m], {ex.addr[23:0], nbeats[7:0]});
            check_eq("w_last", d_wlast[m], nbeats == int'(ex.len));
            check_eq("perr_beat", perr[m], exp_pe);
            check_eq("g_wready", wready[m][g], 1'b1);
            if (nbeats == int'(ex.len)) in_resp = 1'b1;
            nbeats++;
            if (abort_beats > 0 && nbeats == abort_beats) done = 1'b1;
          end else begin
            check_eq("stray_w", d_wvalid[m], 1'b0);
          end
        end else begin
          check_eq("perr_idle", perr[m], 1'b0);
        end
      end
      cyc++;
      if (cyc >= max_cyc && !done) begin
        check_eq("timeout_pending", pend.size(), 0);
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        tog = ~tog;
      end
    end
    if (abort_beats == 0) check_eq("sb_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check_quiet("reset_outputs", m);
      check_eq("read_tieoff", {d_arvalid[m], d_rready[m], arready[m][0], arready[m][1], rvalid[m][0],
                               rvalid[m][1], rdata[m][0], rdata[m][1]}, 70'd0);
    end
    rst_n = 1'b1;

    // single r0 burst, B two cycles late
    b_delay = 2;
    req_exp(0, 32'h0000_1000, 8'd3, -1);
    run(0, 0, 200);
    check_eq("aw_latency", first_aw_cyc, 1);
    b_delay = 0;

    // round-robin contention from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_exp(0, 32'h0000_2000 + 32'(i * 256), 8'd0, -1);
      req_exp(1, 32'h0000_3010 + 32'(i * 256), 8'd0, -1);
    end
    run(0, 0, 400);

    // fixed priority: r1 waits until r0 has nothing left
    for (int i = 0; i < 3; i++) req_exp(0, 32'h0000_4000 + 32'(i * 256), 8'd1, -1);
    req_exp(1, 32'h0000_4820, 8'd1, -1);
    run(1, 0, 400);

    // early requester WLAST on beat 1 of a 2-beat burst
    req_exp(1, 32'h0000_5030, 8'd1, 0);
    run(0, 0, 100);

    // long burst under backpressure on every channel
    aw_stall = 5; wr_toggle = 1'b1; b_delay = 10;
    req_exp(0, 32'h0000_6010, 8'd255, -1);
    run(0, 0, 2000);
    aw_stall = 0; wr_toggle = 1'b0; b_delay = 0;

    // reset in the middle of an r1 burst; r0 must win afterwards
    req_exp(1, 32'h0000_8000, 8'd7, -1);
    run(0, 2, 200);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_quiet("midburst_reset", 0);
    pend.delete();
    sb.delete();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    req_exp(0, 32'h0000_A000, 8'd0, -1);
    req_exp(1, 32'h0000_9010, 8'd0, -1);
    run(0, 0, 200);
    check_eq("post_reset_latency", first_aw_cyc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
